i8088_axil_regs: RTL and testbench
==================================

# i8088_axil_regs

AXI4-Lite responder holding the register window that the 8088 bus bridge reaches through its AXI master port. It gives CPU software scratch registers, an ID word, a free-running tick counter and a write-event counter, all addressed through AXI. It sits on the AXI_CLK domain alongside the bridge and answers every transaction with OKAY, SLVERR or DECERR, so bridge-side `axi_busy` always clears.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `BASE_ADDR`, 32'h0000_1000: window base; must be 256-byte aligned.
- `ID_VALUE`, 32'h8088_0001: constant returned by the ID register.
- `AXI_CLK` in 1: sole clock; all logic on its rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `AXI_awaddr` in ADDR_WIDTH: write address. `AXI_awvalid` in 1. `AXI_awready` out 1.
- `AXI_wdata` in 32: write data. `AXI_wstrb` in 4: byte strobes. `AXI_wvalid` in 1. `AXI_wready` out 1.
- `AXI_bresp` out 2: write response. `AXI_bvalid` out 1. `AXI_bready` in 1.
- `AXI_araddr` in ADDR_WIDTH: read address. `AXI_arvalid` in 1. `AXI_arready` out 1.
- `AXI_rdata` out 32: read data. `AXI_rresp` out 2: read response. `AXI_rvalid` out 1. `AXI_rready` in 1.
- `AXI_awprot` and `AXI_arprot` in 3: accepted and ignored.

## Operation
- **Window.** An access is in the window when `addr[ADDR_WIDTH-1:8] == BASE_ADDR[ADDR_WIDTH-1:8]`. Register select is `addr[7:2]`; `addr[1:0]` is ignored.
- **0x00–0x1C: SCRATCH0..7.** Read/write. Each byte lane is updated only where `wstrb` is 1.
- **0x20: ID.** Read-only; reads `ID_VALUE`.
- **0x24: TICK.** Read-only. Increments by 1 every cycle and wraps 0xFFFF_FFFF→0.
- **0x28: WRCNT.** Read-only. Bits [15:0] count write transactions that returned OKAY, wrapping at 16 bits. Bits [31:16] read 0.
- **Responses.**
  - Write to SCRATCH: `bresp`=2'b00 (OKAY).
  - Write to ID, TICK, WRCNT or an unmapped in-window offset: 2'b10 (SLVERR), no state change.
  - Read of an unmapped in-window offset: 0 with OKAY.
  - Any access outside the window: DECERR (2'b11), `rdata`=0, no state change.
- **Write channel.**
  - AW and W are captured independently into holding registers `aw_held` and `w_held`, in either order or in the same cycle.
  - `AXI_awready` = !aw_held && !bvalid. `AXI_wready` = !w_held && !bvalid.
  - Once both holding registers are full, the write commits at the next edge. At that same edge `bvalid` rises, both holding registers clear, and WRCNT increments if the response is OKAY.
  - `bvalid` and `bresp` hold stable until the cycle in which `bready` is 1; `bvalid` drops at the following edge.
- **Read channel.**
  - `AXI_arready` = !rvalid.
  - On the AR handshake edge, `rdata`, `rresp` and `rvalid` are registered from the current register state.
  - `rvalid` and `rdata` hold until `rready`.
- **Same-cycle read and write of one register.** A read handshake in the same cycle as a write commit edge returns the pre-write value. TICK returns its value before that edge's increment.
- **Reset.**
  - Outputs: `awready`, `wready`, `arready`, `bvalid` and `rvalid` are 0; `bresp`, `rresp` and `rdata` are 0.
  - State: SCRATCH, TICK, WRCNT and both holding registers are 0.
  - Reset asserted mid-transaction discards pending AW, W, B and R with no response. The readies read 0 while `RESET`=1 and rise in the first cycle after it.

## Timing
- **Write, AW and W together.** AW and W handshake in cycle T → `bvalid`=1 in T+1; register updated from T+1.
- **Write, AW before W.** AW in T, W in T+k → `bvalid` in T+k+1. `awready` stays 0 from T+1 until the B handshake completes.
- **Write throughput.** Back-to-back writes: one per 2 cycles when `bready` is held 1.
- **Read, rready held 1.** AR in T → `rvalid` in T+1. `arready` is 0 in T+1 and returns to 1 in T+2, giving one read per 2 cycles.
- **Read, rready low.** With `rready`=0, `rvalid` and `rdata` are held indefinitely and no new AR is accepted.
- **Independence.** The read and write channels are fully independent; neither stalls the other.

## Test plan
- **Basic write/readback.** Write SCRATCH3 (0x100C) with 0xDEADBEEF and wstrb 4'b1111 → OKAY. Then write 0x000000AA with wstrb 4'b0001 → read returns 0xDEADBEAA, OKAY. WRCNT=2.
- **AW/W ordering.** Present AW alone for 5 cycles, then W → `bvalid` exactly 1 cycle after W handshake. Repeat with W first, then with both in the same cycle. Each completes with `bvalid` 1 cycle after the later of the two handshakes.
- **Error responses.**
  - Write to ID (0x1020) → SLVERR; read of ID still returns 0x80880001; WRCNT unchanged.
  - Read 0x2000 → DECERR, `rdata`=0. Read 0x1040 → 0 with OKAY.
- **Backpressure.** Hold `bready`=0 and `rready`=0 for 10 cycles after a transaction → `bvalid`, `rvalid` and data remain stable. `awready`, `wready` and `arready` stay 0 until each respective channel is released.
- **Same-cycle collision and TICK.**
  - Same-cycle read of SCRATCH0 with commit of a write of 0x12345678 (old value 0) → read returns 0; a subsequent read returns 0x12345678.
  - Two TICK reads with AR handshakes N cycles apart → values differ by N.
- **Reset mid-operation.** Assert `RESET` for 1 cycle with `bvalid`=1 pending → all valids are 0 and all readies 0 during reset. Next cycle the readies are 1 and SCRATCH, TICK and WRCNT read 0.

Source files
------------

// File: rtl/i8088_axil_regs.sv
`timescale 1ns/1ps
// i8088_axil_regs: AXI4-Lite register window behind the 8088 bus bridge.
// Scratch, ID, free-running TICK and OKAY-write counter; every access is answered.
module i8088_axil_regs #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_1000,
  parameter logic [31:0]           ID_VALUE   = 32'h8088_0001
) (
  input  logic                  AXI_CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] AXI_awaddr,
  input  logic [2:0]            AXI_awprot,
  input  logic                  AXI_awvalid,
  output logic                  AXI_awready,
  input  logic [31:0]           AXI_wdata,
  input  logic [3:0]            AXI_wstrb,
  input  logic                  AXI_wvalid,
  output logic                  AXI_wready,
  output logic [1:0]            AXI_bresp,
  output logic                  AXI_bvalid,
  input  logic                  AXI_bready,
  input  logic [ADDR_WIDTH-1:0] AXI_araddr,
  input  logic [2:0]            AXI_arprot,
  input  logic                  AXI_arvalid,
  output logic                  AXI_arready,
  output logic [31:0]           AXI_rdata,
  output logic [1:0]            AXI_rresp,
  output logic                  AXI_rvalid,
  input  logic                  AXI_rready
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [5:0] SEL_ID      = 6'h08;
  localparam logic [5:0] SEL_TICK    = 6'h09;
  localparam logic [5:0] SEL_WRCNT   = 6'h0A;

  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_p0;
  logic [31:0]           w_data_p0;
  logic [3:0]            w_strb_p0;

  logic                  bvld_p1;
  logic [1:0]            bresp_p1;
  logic                  rvld_p1;
  logic [1:0]            rresp_p1;
  logic [31:0]           rdata_p1;

  logic [31:0]           scratch [8];
  logic [31:0]           tick;
  logic [15:0]           wrcnt;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [1:0]            wr_resp;
  logic [5:0]            ar_sel;
  logic [31:0]           rd_word;
  logic [1:0]            rd_resp;
  logic                  unused_bits;

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:8] == BASE_ADDR[ADDR_WIDTH-1:8];
  endfunction

  // Only the eight SCRATCH words (offsets 0x00-0x1C) are writable.
  function automatic logic [1:0] wr_resp_of(input logic [ADDR_WIDTH-1:0] a);
    if (!in_window(a)) return RESP_DECERR;
    if (a[7:5] == 3'd0) return RESP_OKAY;
    return RESP_SLVERR;
  endfunction

  assign AXI_awready = !RESET && !aw_held && !bvld_p1;
  assign AXI_wready  = !RESET && !w_held && !bvld_p1;
  assign AXI_arready = !RESET && !rvld_p1;

  assign aw_hs = AXI_awvalid && AXI_awready;
  assign w_hs  = AXI_wvalid && AXI_wready;
  assign ar_hs = AXI_arvalid && AXI_arready;

  // A channel arriving this cycle is used directly so commit needs no extra cycle.
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs) && !bvld_p1;
  assign wr_addr = aw_held ? aw_addr_p0 : AXI_awaddr;
  assign wr_data = w_held ? w_data_p0 : AXI_wdata;
  assign wr_strb = w_held ? w_strb_p0 : AXI_wstrb;
  assign wr_resp = wr_resp_of(wr_addr);

  assign ar_sel = AXI_araddr[7:2];

  assign unused_bits = ^{AXI_awprot, AXI_arprot, AXI_araddr[1:0], wr_addr[1:0]};

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    if (!in_window(AXI_araddr)) begin
      rd_resp = RESP_DECERR;
    end else if (ar_sel[5:3] == 3'd0) begin
      rd_word = scratch[ar_sel[2:0]];
    end else begin
      case (ar_sel)
        SEL_ID:    rd_word = ID_VALUE;
        SEL_TICK:  rd_word = tick;
        SEL_WRCNT: rd_word = {16'h0000, wrcnt};
        default:   rd_word = '0;
      endcase
    end
  end

  // p0 -> p1: AW/W holding registers feed the commit and B response
  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr_p0 <= '0;
      w_data_p0  <= '0;
      w_strb_p0  <= '0;
      bvld_p1    <= 1'b0;
      bresp_p1   <= RESP_OKAY;
      wrcnt      <= '0;
      for (int i = 0; i < 8; i++) scratch[i] <= '0;
    end else if (commit) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvld_p1  <= 1'b1;
      bresp_p1 <= wr_resp;
      if (wr_resp == RESP_OKAY) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) scratch[wr_addr[4:2]][8*b +: 8] <= wr_data[8*b +: 8];
        end
        wrcnt <= wrcnt + 16'd1;
      end
    end else begin
      if (aw_hs) begin
        aw_held    <= 1'b1;
        aw_addr_p0 <= AXI_awaddr;
      end
      if (w_hs) begin
        w_held    <= 1'b1;
        w_data_p0 <= AXI_wdata;
        w_strb_p0 <= AXI_wstrb;
      end
      if (bvld_p1 && AXI_bready) bvld_p1 <= 1'b0;
    end
  end

  // AR -> p1: read data sampled from pre-edge register state
  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      rvld_p1  <= 1'b0;
      rresp_p1 <= RESP_OKAY;
      rdata_p1 <= '0;
    end else if (ar_hs) begin
      rvld_p1  <= 1'b1;
      rresp_p1 <= rd_resp;
      rdata_p1 <= rd_word;
    end else if (rvld_p1 && AXI_rready) begin
      rvld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge AXI_CLK) begin
    if (RESET) tick <= '0;
    else       tick <= tick + 32'd1;
  end

  assign AXI_bvalid = bvld_p1;
  assign AXI_bresp  = bresp_p1;
  assign AXI_rvalid = rvld_p1;
  assign AXI_rresp  = rresp_p1;
  assign AXI_rdata  = rdata_p1;

endmodule

// File: tb/tb_i8088_axil_regs.sv
`timescale 1ns/1ps
// Bench for i8088_axil_regs: directed scenarios plus randomized traffic,
// expected responses queued by a register-map model and popped by a monitor.
module tb_i8088_axil_regs;

  localparam int P = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;

  always #(P/2) clk = ~clk;

  i8088_axil_regs dut (
    .AXI_CLK(clk), .RESET(rst),
    .AXI_awaddr(awaddr), .AXI_awprot(awprot), .AXI_awvalid(awvalid), .AXI_awready(awready),
    .AXI_wdata(wdata), .AXI_wstrb(wstrb), .AXI_wvalid(wvalid), .AXI_wready(wready),
    .AXI_bresp(bresp), .AXI_bvalid(bvalid), .AXI_bready(bready),
    .AXI_araddr(araddr), .AXI_arprot(arprot), .AXI_arvalid(arvalid), .AXI_arready(arready),
    .AXI_rdata(rdata), .AXI_rresp(rresp), .AXI_rvalid(rvalid), .AXI_rready(rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (register map as plain arrays) ----------------
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [31:0] m_scr [8];
  logic [15:0] m_wrcnt;
  time         t_rst = 0;
  bit          m_pa, m_pw;
  logic [31:0] m_pa_addr, m_pw_data;
  logic [3:0]  m_pw_strb;
  rexp_t       rq [$];
  logic [1:0]  bq [$];

  function automatic rexp_t model_read(input logic [31:0] a, input logic [31:0] tk);
    rexp_t e;
    logic [7:0] off;
    e.data = '0;
    e.resp = 2'b00;
    off = a[7:0] & 8'hFC;
    if (a[31:8] != 24'h000010) e.resp = 2'b11;
    else if (off < 8'h20)      e.data = m_scr[off[4:2]];
    else if (off == 8'h20)     e.data = 32'h8088_0001;
    else if (off == 8'h24)     e.data = tk;
    else if (off == 8'h28)     e.data = {16'h0000, m_wrcnt};
    return e;
  endfunction

  function automatic logic [1:0] model_wresp(input logic [31:0] a);
    if (a[31:8] != 24'h000010) return 2'b11;
    if (a[7:0] < 8'h20) return 2'b00;
    return 2'b10;
  endfunction

  // Observes handshakes that will happen at the coming edge; reads before writes.
  always @(negedge clk) begin : model
    logic [31:0] tk;
    logic [1:0]  wr;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_scr[i] = '0;
      m_wrcnt = '0;
      m_pa = 0;
      m_pw = 0;
      rq.delete();
      bq.delete();
      t_rst = $time + P/2;
    end else begin
      if (arvalid && arready) begin
        tk = 32'((($time + 64'd5 - t_rst) / 64'd10) - 64'd1);
        rq.push_back(model_read(araddr, tk));
      end
      if (awvalid && awready) begin m_pa = 1; m_pa_addr = awaddr; end
      if (wvalid && wready) begin m_pw = 1; m_pw_data = wdata; m_pw_strb = wstrb; end
      if (m_pa && m_pw) begin
        wr = model_wresp(m_pa_addr);
        bq.push_back(wr);
        if (wr == 2'b00) begin
          for (int b = 0; b < 4; b++)
            if (m_pw_strb[b]) m_scr[m_pa_addr[4:2]][8*b +: 8] = m_pw_data[8*b +: 8];
          m_wrcnt = m_wrcnt + 16'd1;
        end
        m_pa = 0;
        m_pw = 0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [1:0] eb;
    rexp_t      er;
    if (!rst && bvalid && bready) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_spurious: got bresp %h expected no response", bresp);
      end else begin
        eb = bq.pop_front();
        chk("bresp", 32'(bresp), 32'(eb));
      end
    end
    if (!rst && rvalid && rready) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_spurious: got rdata %h expected no response", rdata);
      end else begin
        er = rq.pop_front();
        chk("rdata", rdata, er.data);
        chk("rresp", 32'(rresp), 32'(er.resp));
      end
    end
  end

  // ---------------- drivers ----------------
  bit aw_done_f, w_done_f;

  task automatic drive_aw(input logic [31:0] a, input int dly, output bit ok);
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a; awprot = 3'($urandom_range(0, 7)); awvalid = 1'b1; ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (awready) begin
        if (w_done_f) chk("wready_held", 32'(wready), 32'd0);
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    aw_done_f = ok;
    if (!ok) begin checks++; errors++; $display("FAIL aw_timeout: got no awready expected handshake"); end
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly, output bit ok);
    repeat (dly) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wvalid = 1'b1; ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wready) begin
        if (aw_done_f) chk("awready_held", 32'(awready), 32'd0);
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    wvalid = 1'b0;
    w_done_f = ok;
    if (!ok) begin checks++; errors++; $display("FAIL w_timeout: got no wready expected handshake"); end
  endtask

  task automatic write_tx(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
    bit oka, okw;
    aw_done_f = 0;
    w_done_f = 0;
    fork
      drive_aw(a, aw_dly, oka);
      drive_w(d, s, w_dly, okw);
    join
    if (oka && okw) chk("b_latency", 32'(bvalid), 32'd1);
  endtask

  task automatic wait_b(output logic [1:0] r);
    bit ok = 0;
    r = 2'bxx;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bvalid && bready) begin r = bresp; ok = 1; break; end
    end
    @(posedge clk); #1;
    if (!ok) begin checks++; errors++; $display("FAIL b_timeout: got no bvalid expected response"); end
  endtask

  task automatic read_tx(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                         output time t_hs);
    bit ok = 0;
    araddr = a; arprot = 3'($urandom_range(0, 7)); arvalid = 1'b1;
    d = 'x; r = 'x; t_hs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    @(posedge clk);
    t_hs = $time;
    #1;
    arvalid = 1'b0;
    if (ok) begin
      chk("r_latency", 32'(rvalid), 32'd1);
      chk("arready_busy", 32'(arready), 32'd0);
      d = rdata;
      r = rresp;
    end else begin
      checks++; errors++; $display("FAIL ar_timeout: got no arready expected handshake");
    end
  endtask

  task automatic wait_r();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rvalid && rready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (!ok) begin checks++; errors++; $display("FAIL r_timeout: got no rvalid expected response"); end
  endtask

  function automatic logic [31:0] pick_addr();
    int k;
    logic [31:0] a;
    k = $urandom_range(0, 9);
    if (k <= 6)      a = 32'h1000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
    else if (k == 7) a = 32'h1000 + 32'($urandom_range(8'h30, 8'hFF));
    else if (k == 8) begin
      a = $urandom;
      if (a[31:8] == 24'h000010) a[31] = 1'b1;
    end else         a = 32'h1024;
    return a;
  endfunction

  initial begin : watchdog
    #(500_000);
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] d, v1, v2, wc0;
    logic [1:0]  r, br;
    time         t1, t2, unused_t;
    bit          wl_done, rl_done;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_rresp", 32'(rresp), 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_awready", 32'(awready), 1);
    chk("post_rst_arready", 32'(arready), 1);

    // basic write / partial-strobe readback
    write_tx(32'h100C, 32'hDEAD_BEEF, 4'hF, 0, 0); wait_b(br);
    chk("wr_scr3_resp", 32'(br), 0);
    write_tx(32'h100C, 32'h0000_00AA, 4'h1, 0, 0); wait_b(br);
    read_tx(32'h100C, d, r, unused_t); wait_r();
    chk("scr3_merge", d, 32'hDEAD_BEAA);
    chk("scr3_resp", 32'(r), 0);
    read_tx(32'h1028, d, r, unused_t); wait_r();
    chk("wrcnt_2", d, 32'd2);

    // AW/W ordering
    write_tx(32'h1004, 32'h1111_1111, 4'hF, 0, 5); wait_b(br);
    write_tx(32'h1008, 32'h2222_2222, 4'hF, 5, 0); wait_b(br);
    write_tx(32'h1010, 32'h3333_3333, 4'hF, 0, 0); wait_b(br);
    read_tx(32'h1008, d, r, unused_t); wait_r();
    chk("scr2_readback", d, 32'h2222_2222);

    // error responses
    read_tx(32'h1028, wc0, r, unused_t); wait_r();
    chk("wrcnt_5", wc0, 32'd5);
    write_tx(32'h1020, 32'hFFFF_FFFF, 4'hF, 0, 0); wait_b(br);
    chk("id_wr_slverr", 32'(br), 32'h2);
    read_tx(32'h1020, d, r, unused_t); wait_r();
    chk("id_value", d, 32'h8088_0001);
    read_tx(32'h1028, d, r, unused_t); wait_r();
    chk("wrcnt_after_slverr", d, wc0);
    read_tx(32'h2000, d, r, unused_t); wait_r();
    chk("decerr_resp", 32'(r), 32'h3);
    chk("decerr_data", d, 0);
    read_tx(32'h1040, d, r, unused_t); wait_r();
    chk("unmapped_resp", 32'(r), 0);
    chk("unmapped_data", d, 0);
    write_tx(32'h3000, 32'h1234_0000, 4'hF, 1, 0); wait_b(br);
    chk("wr_decerr", 32'(br), 32'h3);

    // backpressure
    bready = 1'b0;
    rready = 1'b0;
    fork
      write_tx(32'h1014, 32'hCAFE_F00D, 4'hF, 0, 0);
      read_tx(32'h1004, d, r, unused_t);
    join
    repeat (10) begin
      @(negedge clk);
      chk("bp_bvalid", 32'(bvalid), 1);
      chk("bp_bresp", 32'(bresp), 0);
      chk("bp_rvalid", 32'(rvalid), 1);
      chk("bp_rdata", rdata, 32'h1111_1111);
      chk("bp_awready", 32'(awready), 0);
      chk("bp_wready", 32'(wready), 0);
      chk("bp_arready", 32'(arready), 0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    wait_b(br);
    chk("bp_awready_free", 32'(awready), 1);
    chk("bp_wready_free", 32'(wready), 1);
    chk("bp_arready_still", 32'(arready), 0);
    rready = 1'b1;
    wait_r();
    chk("bp_arready_free", 32'(arready), 1);

    // same-cycle read and commit of SCRATCH0
    fork
      write_tx(32'h1000, 32'h1234_5678, 4'hF, 0, 0);
      read_tx(32'h1000, d, r, unused_t);
    join
    chk("collide_old", d, 0);
    fork
      wait_b(br);
      wait_r();
    join
    read_tx(32'h1000, d, r, unused_t); wait_r();
    chk("collide_new", d, 32'h1234_5678);

    // TICK spacing
    read_tx(32'h1024, v1, r, t1); wait_r();
    repeat (7) begin @(posedge clk); #1; end
    read_tx(32'h1024, v2, r, t2); wait_r();
    chk("tick_delta", v2 - v1, 32'((t2 - t1) / 64'd10));

    // randomized traffic on both channels with random backpressure
    wl_done = 0;
    rl_done = 0;
    fork
      begin
        repeat (40) begin
          write_tx(pick_addr(), $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 3));
          wait_b(br);
        end
        wl_done = 1;
      end
      begin
        repeat (40) begin
          read_tx(pick_addr(), d, r, unused_t);
          wait_r();
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rl_done = 1;
      end
      begin
        while (!(wl_done && rl_done)) begin
          @(posedge clk); #1;
          bready = 1'($urandom_range(0, 1));
          rready = 1'($urandom_range(0, 1));
        end
      end
    join
    bready = 1'b1;
    rready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // reset with B and R pending
    bready = 1'b0;
    rready = 1'b0;
    fork
      write_tx(32'h1018, 32'h5555_AAAA, 4'hF, 0, 0);
      read_tx(32'h1018, d, r, unused_t);
    join
    rst = 1'b1;
    araddr = 32'h1024;
    arvalid = 1'b1;
    @(negedge clk);
    chk("mid_rst_awready", 32'(awready), 0);
    chk("mid_rst_wready", 32'(wready), 0);
    chk("mid_rst_arready", 32'(arready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rready = 1'b1;
    bready = 1'b1;
    #1;
    chk("after_rst_bvalid", 32'(bvalid), 0);
    chk("after_rst_rvalid", 32'(rvalid), 0);
    chk("after_rst_awready", 32'(awready), 1);
    chk("after_rst_wready", 32'(wready), 1);
    chk("after_rst_arready", 32'(arready), 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("first_tick_valid", 32'(rvalid), 1);
    chk("first_tick", rdata, 0);
    wait_r();
    read_tx(32'h1018, d, r, unused_t); wait_r();
    chk("rst_scr6", d, 0);
    read_tx(32'h100C, d, r, unused_t); wait_r();
    chk("rst_scr3", d, 0);
    read_tx(32'h1028, d, r, unused_t); wait_r();
    chk("rst_wrcnt", d, 0);

    repeat (4) begin @(posedge clk); #1; end
    chk("bq_drained", 32'(bq.size()), 0);
    chk("rq_drained", 32'(rq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
